// File: rtl/usb_fs_rx_decoder.sv
// Full-speed USB receive front end.
// Registers DP/DM into LineState, detects SYNC, NRZI-decodes and unstuffs the
// bit stream, packs bytes LSB-first, detects EOP and reports errors. The SIE
// sees a UTMI-style RxActive/RxValid/RxError/DataOut stream.
// Ports:
//   UTMI_clk  - bit clock, one line symbol per cycle
//   Rst       - synchronous active-high reset
//   DP, DM    - bus pads
//   TX_en     - local transmitter active, receive path blanked
//   LineState - registered line state {DM,DP}: 00 SE0, 01 J, 10 K, 11 SE1
//   RxActive  - packet in progress
//   RxValid   - one-cycle strobe, DataOut holds a complete byte
//   RxError   - one-cycle strobe, receive error
//   DataOut   - received byte, LSB first on the wire
module usb_fs_rx_decoder #(
  parameter int unsigned SYNC_MIN_KJ = 3,
  parameter int unsigned EOP_SE0_MIN = 2,
  parameter int unsigned ERR_IDLE_J  = 8
) (
  input  logic       UTMI_clk,
  input  logic       Rst,
  input  logic       DP,
  input  logic       DM,
  input  logic       TX_en,
  output logic [1:0] LineState,
  output logic       RxActive,
  output logic       RxValid,
  output logic       RxError,
  output logic [7:0] DataOut
);

  localparam int unsigned KJ_W   = $clog2(SYNC_MIN_KJ + 1);
  localparam int unsigned SE0_W  = $clog2(EOP_SE0_MIN + 1);
  localparam int unsigned ERRJ_W = $clog2(ERR_IDLE_J + 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          ls_prev;
  logic [KJ_W-1:0]     kj_cnt, kj_cnt_nxt;
  logic [2:0]          bit_cnt, bit_cnt_nxt;
  logic [2:0]          ones_cnt, ones_cnt_nxt;
  logic [7:0]          shreg, shreg_nxt;
  logic [SE0_W-1:0]    se0_cnt, se0_cnt_nxt;
  logic [ERRJ_W-1:0]   errj_cnt, errj_cnt_nxt;
  logic                rx_active_nxt, rx_valid_nxt, rx_error_nxt;
  logic [7:0]          data_out_nxt;
  logic                data_bit_c;

  // NRZI: an unchanged J/K symbol is a 1
  assign data_bit_c = (LineState == ls_prev);

  // State and output registers
  always_ff @(posedge UTMI_clk) begin
    if (Rst) begin
      state     <= ST_IDLE;
      LineState <= LS_J;
      ls_prev   <= LS_J;
      kj_cnt    <= '0;
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      shreg     <= '0;
      se0_cnt   <= '0;
      errj_cnt  <= '0;
      RxActive  <= 1'b0;
      RxValid   <= 1'b0;
      RxError   <= 1'b0;
      DataOut   <= '0;
    end else begin
      state     <= state_nxt;
      LineState <= {DM, DP};
      ls_prev   <= LineState;
      kj_cnt    <= kj_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      ones_cnt  <= ones_cnt_nxt;
      shreg     <= shreg_nxt;
      se0_cnt   <= se0_cnt_nxt;
      errj_cnt  <= errj_cnt_nxt;
      RxActive  <= rx_active_nxt;
      RxValid   <= rx_valid_nxt;
      RxError   <= rx_error_nxt;
      DataOut   <= data_out_nxt;
    end
  end

  // Next-state and output decode, driven by LineState against its previous value
  always_comb begin
    state_nxt     = state;
    kj_cnt_nxt    = kj_cnt;
    bit_cnt_nxt   = bit_cnt;
    ones_cnt_nxt  = ones_cnt;
    shreg_nxt     = shreg;
    se0_cnt_nxt   = se0_cnt;
    errj_cnt_nxt  = errj_cnt;
    rx_active_nxt = RxActive;
    rx_valid_nxt  = 1'b0;
    rx_error_nxt  = 1'b0;
    data_out_nxt  = DataOut;

    unique case (state)
      ST_IDLE: begin
        rx_active_nxt = 1'b0;
        if (LineState == LS_K) begin
          state_nxt  = ST_SYNC;
          kj_cnt_nxt = '0;
        end
      end

      ST_SYNC: begin
        unique case (LineState)
          LS_K: begin
            // KK closes the SYNC pattern
            if (ls_prev == LS_K) begin
              if (kj_cnt >= KJ_W'(SYNC_MIN_KJ)) begin
                state_nxt     = ST_DATA;
                rx_active_nxt = 1'b1;
                bit_cnt_nxt   = '0;
                ones_cnt_nxt  = '0;
              end else begin
                state_nxt = ST_IDLE;
              end
            end
          end
          LS_J: begin
            if (ls_prev == LS_K) begin
              if (kj_cnt < KJ_W'(SYNC_MIN_KJ)) kj_cnt_nxt = kj_cnt + KJ_W'(1);
            end else if (ls_prev == LS_J || ls_prev == LS_SE0) begin
              state_nxt = ST_IDLE;
            end
          end
          LS_SE0: begin
            if (ls_prev == LS_J || ls_prev == LS_SE0) state_nxt = ST_IDLE;
          end
          default: begin
            state_nxt    = ST_ERROR;
            rx_error_nxt = 1'b1;
            errj_cnt_nxt = '0;
          end
        endcase
      end

      ST_DATA: begin
        if (LineState == LS_SE0) begin
          state_nxt   = ST_EOP;
          se0_cnt_nxt = SE0_W'(1);
        end else if (LineState == LS_SE1) begin
          state_nxt    = ST_ERROR;
          rx_error_nxt = 1'b1;
          errj_cnt_nxt = '0;
        end else if (ones_cnt == 3'd6) begin
          // Bit after six 1s must be a stuffed 0
          if (data_bit_c) begin
            state_nxt    = ST_ERROR;
            rx_error_nxt = 1'b1;
            errj_cnt_nxt = '0;
          end else begin
            ones_cnt_nxt = '0;
          end
        end else begin
          shreg_nxt    = {data_bit_c, shreg[7:1]};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          ones_cnt_nxt = data_bit_c ? ones_cnt + 3'd1 : 3'd0;
          if (bit_cnt == 3'd7) begin
            rx_valid_nxt = 1'b1;
            data_out_nxt = {data_bit_c, shreg[7:1]};
          end
        end
      end

      ST_EOP: begin
        if (LineState == LS_SE0) begin
          if (se0_cnt < SE0_W'(EOP_SE0_MIN)) se0_cnt_nxt = se0_cnt + SE0_W'(1);
        end else if (LineState == LS_J && se0_cnt >= SE0_W'(EOP_SE0_MIN) &&
                     bit_cnt == 3'd0) begin
          state_nxt     = ST_IDLE;
          rx_active_nxt = 1'b0;
        end else begin
          state_nxt    = ST_ERROR;
          rx_error_nxt = 1'b1;
          errj_cnt_nxt = '0;
        end
      end

      ST_ERROR: begin
        if (LineState == LS_J) begin
          if (ls_prev == LS_SE0 || errj_cnt == ERRJ_W'(ERR_IDLE_J - 1)) begin
            state_nxt     = ST_IDLE;
            rx_active_nxt = 1'b0;
          end else begin
            errj_cnt_nxt = errj_cnt + ERRJ_W'(1);
          end
        end else begin
          errj_cnt_nxt = '0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Local transmit blanks the receiver and abandons any packet silently
    if (TX_en) begin
      state_nxt     = ST_IDLE;
      rx_active_nxt = 1'b0;
      rx_valid_nxt  = 1'b0;
      rx_error_nxt  = 1'b0;
    end
  end

endmodule
